// File: rtl/acq_sequencer.sv
// Acquisition sequencer: pre-trigger fill, armed wait, post-trigger capture, readout hand-off.
// Optional build macro AUTO_REARM_EN: ReadoutDone in DONE restarts PREFILL instead of returning to IDLE.
module acq_sequencer #(
   parameter int ADDR_W       = 10,
   parameter int PRE_SAMPLES  = 256,
   parameter int POST_SAMPLES = 512
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [7:0]        Cmd,
   input  logic              CmdValid,
   input  logic              TrigIn,
   input  logic              ReadoutDone,
   output logic              BufWrEn,
   output logic [ADDR_W-1:0] BufWrAddr,
   output logic [ADDR_W-1:0] TrigAddr,
   output logic              TriggerArmed,
   output logic              DataReady,
   output logic              Busy
);

   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_SAMPLES - 1);
   localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_SAMPLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      PREFILL,
      ARMED,
      POST,
      DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [ADDR_W-1:0] trig_addr_reg, trig_addr_next;
   logic [ADDR_W-1:0] pre_cnt_reg, pre_cnt_next;
   logic [ADDR_W-1:0] post_cnt_reg, post_cnt_next;
   logic              trig_prev_reg;

   logic cmd_arm, cmd_abort, cmd_force, trig_edge;

   assign cmd_arm   = CmdValid && (Cmd == 8'd65);
   assign cmd_abort = CmdValid && (Cmd == 8'd97);
   assign cmd_force = CmdValid && (Cmd == 8'd70);
   assign trig_edge = TrigIn && !trig_prev_reg;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         trig_addr_reg <= '0;
         pre_cnt_reg   <= '0;
         post_cnt_reg  <= '0;
         trig_prev_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         trig_addr_reg <= trig_addr_next;
         pre_cnt_reg   <= pre_cnt_next;
         post_cnt_reg  <= post_cnt_next;
         trig_prev_reg <= TrigIn;
      end
   end

   // The final write of a capture (and an aborted write) leaves the address
   // pointing at the last sample written, so it is not advanced on that cycle.
   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      trig_addr_next = trig_addr_reg;
      pre_cnt_next   = pre_cnt_reg;
      post_cnt_next  = post_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (cmd_arm) begin
               state_next   = PREFILL;
               addr_next    = '0;
               pre_cnt_next = '0;
            end
         end
         PREFILL: begin
            if (cmd_abort) begin
               state_next = IDLE;
            end else begin
               addr_next    = addr_reg + ADDR_ONE;
               pre_cnt_next = pre_cnt_reg + ADDR_ONE;
               if (pre_cnt_reg == PRE_LAST) state_next = ARMED;
            end
         end
         ARMED: begin
            if (cmd_abort) begin
               state_next = IDLE;
            end else if (trig_edge || cmd_force) begin
               trig_addr_next = addr_reg;
               post_cnt_next  = ADDR_ONE;
               if (POST_SAMPLES == 1) begin
                  state_next = DONE;
               end else begin
                  state_next = POST;
                  addr_next  = addr_reg + ADDR_ONE;
               end
            end else begin
               addr_next = addr_reg + ADDR_ONE;
            end
         end
         POST: begin
            if (cmd_abort) begin
               state_next = IDLE;
            end else if (post_cnt_reg == POST_LAST) begin
               state_next = DONE;
            end else begin
               post_cnt_next = post_cnt_reg + ADDR_ONE;
               addr_next     = addr_reg + ADDR_ONE;
            end
         end
         DONE: begin
            if (cmd_abort) begin
               state_next = IDLE;
            end else if (ReadoutDone) begin
`ifdef AUTO_REARM_EN
               state_next   = PREFILL;
               addr_next    = '0;
               pre_cnt_next = '0;
`else
               state_next = IDLE;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign BufWrEn      = (state_reg == PREFILL) || (state_reg == ARMED) || (state_reg == POST);
   assign BufWrAddr    = addr_reg;
   assign TrigAddr     = trig_addr_reg;
   assign TriggerArmed = (state_reg == ARMED);
   assign DataReady    = (state_reg == DONE);
   assign Busy         = (state_reg != IDLE);

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Sequences one acquisition into the sample buffer: pre-trigger fill, armed wait, post-trigger capture, then hand-off for readout. It drives the buffer write port, latches the trigger address and reports the armed state. Host commands are the same ASCII command bytes the trigger logic decodes, and it sits between the command decoder, the trigger source and the sample BRAM.

Parameters:
ADDR_W, 10, buffer address width; buffer depth = 2^ADDR_W.
PRE_SAMPLES, 256, writes required before a trigger is accepted (>=1).
POST_SAMPLES, 512, writes after the trigger, including the trigger sample (>=1). PRE_SAMPLES+POST_SAMPLES <= 2^ADDR_W; the bench flags violation with $error.

Ports:
Clock  in  1  system clock
Reset  in  1  reset
Cmd  in  8  command byte
CmdValid  in  1  Cmd is valid this cycle; Cmd ignored when low
TrigIn  in  1  trigger level from comparator; rising edge detected internally
ReadoutDone  in  1  one-cycle pulse from readout logic, buffer consumed
BufWrEn  out  1  sample buffer write enable
BufWrAddr  out  ADDR_W  sample buffer write address
TrigAddr  out  ADDR_W  address written on the trigger cycle
TriggerArmed  out  1  high in ARMED
DataReady  out  1  high in DONE
Busy  out  1  high in any state except IDLE

Behaviour:
- Reset (Reset, synchronous, active-high; clock Clock): state IDLE; BufWrAddr=0, TrigAddr=0, counters=0, TrigPrev=0. All outputs are low except the address buses, which are 0. Reset mid-acquisition aborts immediately with no further writes.
- Commands: 'A'(65) arm, 'a'(97) abort, 'F'(70) force trigger. Acted on only when CmdValid=1; other codes are ignored.
- Outputs are Moore, decoded from registered state. BufWrEn=1 in PREFILL, ARMED and POST. BufWrAddr increments by 1 on every write cycle and wraps (2^ADDR_W-1 -> 0).
- Edge detect: TrigPrev<=TrigIn every cycle in every state. Edge = TrigIn & ~TrigPrev. A level already high when ARMED is entered never triggers.
- IDLE: 'A' -> PREFILL, with BufWrAddr<=0 and PreCnt<=0.
- PREFILL: PreCnt increments per write. On the write with PreCnt==PRE_SAMPLES-1 -> ARMED. Edges and 'F' are ignored.
- ARMED: on Edge or 'F' -> POST. TrigAddr<=BufWrAddr (the address being written this cycle), PostCnt<=1. If POST_SAMPLES==1 -> DONE directly.
- POST: PostCnt increments per write. On the write with PostCnt==POST_SAMPLES-1 -> DONE. Exactly POST_SAMPLES writes, addresses TrigAddr..TrigAddr+POST_SAMPLES-1 mod depth.
- DONE: BufWrEn=0; BufWrAddr and TrigAddr hold. ReadoutDone -> IDLE.
- Abort: 'a' in any non-IDLE state -> IDLE next cycle. The write in the abort cycle still occurs. DataReady is never asserted. BufWrAddr and TrigAddr hold.
- Priority in the same cycle: Reset > 'a' > ReadoutDone > Edge/'F'. 'A' outside IDLE is ignored. ReadoutDone outside DONE is ignored.
- Latency: 'A' at edge k puts the first write (addr 0) in cycle k+1. Armed after exactly PRE_SAMPLES writes.

Optional Feature:
AUTO_REARM_EN
- Defined: in DONE, ReadoutDone -> PREFILL, with BufWrAddr<=0 and PreCnt<=0. Continuous acquisition runs until 'a'. 'a' in DONE -> IDLE.
- Undefined: ReadoutDone -> IDLE; each acquisition requires a new 'A'.

Test Plan:
(All with ADDR_W=4, PRE_SAMPLES=4, POST_SAMPLES=6.)
1. Reset, then CmdValid with 'A' -> BufWrEn high next cycle, addresses 0,1,2,3 written in PREFILL; TriggerArmed rises with the write of addr 4; Busy=1.
2. Armed, TrigIn rises while BufWrAddr=7 -> TrigAddr=7, writes 7..12, then BufWrEn=0, DataReady=1, BufWrAddr holds 12; ReadoutDone pulse -> IDLE, DataReady=0.
3. TrigIn held high from PREFILL into ARMED -> no trigger; CmdValid with 'F' at addr 6 -> TrigAddr=6, 6 writes.
4. Hold ARMED past wrap, trigger at addr 14 -> writes 14,15,0,1,2,3; TrigAddr=14.
5. 'a' in POST after 3 writes -> IDLE next cycle, DataReady never asserted. 'A' issued in POST and Cmd=65 with CmdValid=0 -> both ignored.
6. With AUTO_REARM_EN: ReadoutDone in DONE -> PREFILL, addr restarts at 0. Without it -> IDLE. Reset asserted in POST -> IDLE, all outputs at reset values next cycle.
